// File: rtl/onehot_arb_pkg.sv
// Shared types and helpers for the one-hot round-robin arbiter.
// Holds the FSM state encoding, default sizing and a one-hot to binary encoder.
package onehot_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } arb_state_e;

  localparam int DEFAULT_N        = 3;
  localparam int DEFAULT_MAX_HOLD = 8;
  localparam int MAX_N            = 8;

  // OR-reduction encoder: only valid for zero or one-hot inputs, which is all the arbiter feeds it.
  function automatic logic [2:0] onehot_to_index(input logic [MAX_N-1:0] v);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_N; i++) begin
      if (v[i]) idx = idx | 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set request at or above the one-hot
// pointer, wrapping around, found by searching a doubled request vector.
module rr_pick #(
  parameter int N = 3
) (
  input  logic [N-1:0] req,
  input  logic [N-1:0] ptr,
  output logic [N-1:0] pick,
  output logic         any
);

  logic [2*N-1:0] dreq;
  logic [2*N-1:0] dptr;
  logic [2*N-1:0] first;
  logic           run;
  logic           found;

  assign dreq = {req, req};
  assign dptr = {{N{1'b0}}, ptr};

  // The search is enabled from the pointer position upward; the upper copy supplies the wrap.
  always_comb begin
    first = '0;
    run   = 1'b0;
    found = 1'b0;
    for (int j = 0; j < 2*N; j++) begin
      run = run | dptr[j];
      if (run && dreq[j] && !found) begin
        first[j] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_fold
      assign pick[gi] = first[gi] | first[gi+N];
    end
  endgenerate

  assign any = |req;

endmodule

// File: rtl/onehot_rr_arbiter.sv
// Round-robin arbiter with a one-hot rotating priority token, registered
// one-hot/binary grant outputs, a one-cycle gap after release and a hold timeout.
module onehot_rr_arbiter
  import onehot_arb_pkg::*;
#(
  parameter int N        = DEFAULT_N,
  parameter int MAX_HOLD = DEFAULT_MAX_HOLD,
  parameter int IDW      = $clog2(N)
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [N-1:0]   req,
  input  logic           done,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] grant_id,
  output logic           busy,
  output logic           timeout
);

  localparam int            HW       = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);
  localparam bit            HOLD_EN  = (MAX_HOLD != 0);

  arb_state_e     state_reg, state_next;
  logic [N-1:0]   ptr_reg, ptr_next;
  logic [HW-1:0]  hold_cnt_reg, hold_cnt_next;
  logic [N-1:0]   grant_reg, grant_next;
  logic [IDW-1:0] grant_id_reg, grant_id_next;
  logic           busy_reg, busy_next;
  logic           timeout_reg, timeout_next;

  logic [N-1:0]   pick;
  logic           any;
  logic           rel_done;
  logic           rel_drop;
  logic           rel_hold;

  rr_pick #(.N(N)) u_pick (
    .req  (req),
    .ptr  (ptr_reg),
    .pick (pick),
    .any  (any)
  );

  assign rel_done = done;
  assign rel_drop = ~|(req & grant_reg);
  assign rel_hold = HOLD_EN && (hold_cnt_reg == HOLD_MAX);

  always_comb begin
    state_next    = state_reg;
    ptr_next      = ptr_reg;
    hold_cnt_next = hold_cnt_reg;
    grant_next    = grant_reg;
    grant_id_next = grant_id_reg;
    busy_next     = busy_reg;
    timeout_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (any) begin
          state_next    = GRANT;
          grant_next    = pick;
          grant_id_next = IDW'(onehot_to_index(MAX_N'(pick)));
          busy_next     = 1'b1;
          hold_cnt_next = HOLD_EN ? HW'(1) : '0;
        end
      end
      GRANT: begin
        if (rel_done || rel_drop || rel_hold) begin
          state_next    = GAP;
          grant_next    = '0;
          grant_id_next = '0;
          busy_next     = 1'b0;
          hold_cnt_next = '0;
          ptr_next      = {grant_reg[N-2:0], grant_reg[N-1]};
          // Only a pure timeout is flagged; a voluntary release on the same edge wins.
          timeout_next  = rel_hold && !rel_done && !rel_drop;
        end else if (HOLD_EN && (hold_cnt_reg != HOLD_MAX)) begin
          hold_cnt_next = hold_cnt_reg + HW'(1);
        end
      end
      GAP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      ptr_reg      <= N'(1);
      hold_cnt_reg <= '0;
      grant_reg    <= '0;
      grant_id_reg <= '0;
      busy_reg     <= 1'b0;
      timeout_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      ptr_reg      <= ptr_next;
      hold_cnt_reg <= hold_cnt_next;
      grant_reg    <= grant_next;
      grant_id_reg <= grant_id_next;
      busy_reg     <= busy_next;
      timeout_reg  <= timeout_next;
    end
  end

  assign grant    = grant_reg;
  assign grant_id = grant_id_reg;
  assign busy     = busy_reg;
  assign timeout  = timeout_reg;

endmodule

// File: tb/tb_onehot_rr_arbiter.sv
// Scoreboard bench for onehot_rr_arbiter: a round-robin reference model predicts
// every post-edge output; a monitor compares them, plus directed boundary checks.
module tb_onehot_rr_arbiter;

  localparam int N   = 3;
  localparam int MH  = 4;
  localparam int IDW = 2;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req   = '0;
  logic           done  = 1'b0;
  logic [N-1:0]   grant;
  logic [IDW-1:0] grant_id;
  logic           busy;
  logic           timeout;

  typedef struct {
    logic [N-1:0]   grant;
    logic [IDW-1:0] id;
    logic           busy;
    logic           timeout;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   passed = 0;

  onehot_rr_arbiter #(.N(N), .MAX_HOLD(MH), .IDW(IDW)) dut (
    .clock    (clock),
    .reset    (reset),
    .req      (req),
    .done     (done),
    .grant    (grant),
    .grant_id (grant_id),
    .busy     (busy),
    .timeout  (timeout)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act === exp_v) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
  endtask

  // Reference model: holder index, rotating start index, cycles held, gap flag.
  initial begin
    int   m_holder;
    int   m_ptr;
    int   m_held;
    bit   m_gap;
    bit   to;
    bit   rel_hold;
    bit   found;
    int   idx;
    exp_t e;
    m_holder = -1; m_ptr = 0; m_held = 0; m_gap = 0;
    forever begin
      @(posedge clock or posedge reset);
      if (reset) begin
        m_holder = -1; m_ptr = 0; m_held = 0; m_gap = 0;
        expq.delete();
      end else begin
        to = 1'b0;
        if (m_holder >= 0) begin
          rel_hold = (m_held == MH);
          if (done || !req[m_holder] || rel_hold) begin
            to       = rel_hold && !done && req[m_holder];
            m_ptr    = (m_holder + 1) % N;
            m_holder = -1;
            m_gap    = 1'b1;
          end else if (m_held < MH) begin
            m_held++;
          end
        end else if (m_gap) begin
          m_gap = 1'b0;
        end else begin
          found = 1'b0;
          for (int k = 0; k < N; k++) begin
            idx = (m_ptr + k) % N;
            if (!found && req[idx]) begin
              m_holder = idx;
              m_held   = 1;
              found    = 1'b1;
            end
          end
        end
        e.grant   = (m_holder >= 0) ? N'(1 << m_holder) : '0;
        e.id      = IDW'((m_holder >= 0) ? m_holder : 0);
        e.busy    = (m_holder >= 0);
        e.timeout = to;
        expq.push_back(e);
      end
    end
  end

  // Monitor: compares every predicted cycle and the output invariants.
  initial begin
    exp_t e;
    logic inv_ok;
    forever begin
      @(posedge clock);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        checks++;
        if (grant === e.grant && grant_id === e.id && busy === e.busy && timeout === e.timeout)
          passed++;
        else
          $display("FAIL scoreboard: got g=%b id=%0d busy=%b to=%b expected g=%b id=%0d busy=%b to=%b at %0t",
                   grant, grant_id, busy, timeout, e.grant, e.id, e.busy, e.timeout, $time);
        inv_ok = ((grant & (grant - N'(1))) == '0) && (busy == (grant != '0)) &&
                 ((grant == '0) ? (grant_id == '0) : (grant == N'(1 << grant_id)));
        checks++;
        if (inv_ok) passed++;
        else $display("FAIL invariant: g=%b id=%0d busy=%b at %0t", grant, grant_id, busy, $time);
      end
    end
  end

  task automatic wait_grant(input string name);
    int n;
    n = 0;
    while (grant == '0 && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (grant == '0) begin
      checks++;
      $display("FAIL %s: got no grant expected a grant within 20 cycles", name);
    end
  endtask

  task automatic reset_pulse();
    req  = '0;
    done = 1'b0;
    @(negedge clock); #2 reset = 1'b1;
    @(negedge clock); #2 reset = 1'b0;
    @(negedge clock);
  endtask

  initial begin
    logic [N-1:0] got[4];
    logic [N-1:0] prev;
    int           gcount;
    int           n;

    // Reset and idle
    @(negedge clock);
    chk("reset_grant", 32'(grant), 32'(0));
    chk("reset_busy", 32'(busy), 32'(0));
    chk("reset_id", 32'(grant_id), 32'(0));
    chk("reset_timeout", 32'(timeout), 32'(0));
    @(negedge clock);
    reset = 1'b0;
    repeat (5) @(negedge clock);

    // Rotation with done after each grant
    req = 3'b111; prev = '0; gcount = 0;
    repeat (16) begin
      @(negedge clock);
      if (grant != '0 && prev == '0 && gcount < 4) begin
        got[gcount] = grant;
        gcount++;
      end
      prev = grant;
      done = (grant != '0);
    end
    done = 1'b0; req = '0;
    chk("rot_count", 32'(gcount), 32'(4));
    chk("rot_0", 32'(got[0]), 32'(3'b001));
    chk("rot_1", 32'(got[1]), 32'(3'b010));
    chk("rot_2", 32'(got[2]), 32'(3'b100));
    chk("rot_3", 32'(got[3]), 32'(3'b001));

    // Skip and wrap
    reset_pulse();
    req = 3'b001;
    wait_grant("skip_first");
    req = '0;
    @(negedge clock);
    req = 3'b101;
    wait_grant("skip_second");
    chk("skip_grant", 32'(grant), 32'(3'b100));
    chk("skip_id", 32'(grant_id), 32'(2));
    done = 1'b1;
    @(negedge clock);
    done = 1'b0;
    wait_grant("wrap");
    chk("wrap_grant", 32'(grant), 32'(3'b001));

    // Timeout with steady request
    reset_pulse();
    req = 3'b001;
    wait_grant("to_first");
    n = 0;
    while (grant == 3'b001 && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk("to_hold_len", 32'(n), 32'(MH));
    chk("to_pulse", 32'(timeout), 32'(1));
    @(negedge clock);
    chk("to_clear", 32'(timeout), 32'(0));
    chk("to_idle_grant", 32'(grant), 32'(0));
    @(negedge clock);
    chk("to_regrant", 32'(grant), 32'(3'b001));

    // done on the same edge as the hold limit
    n = 1;
    while (n < MH && grant != '0) begin
      @(negedge clock);
      if (grant != '0) n++;
    end
    done = 1'b1;
    @(negedge clock);
    done = 1'b0;
    chk("simul_release", 32'(grant), 32'(0));
    chk("simul_timeout", 32'(timeout), 32'(0));

    // Asynchronous reset while 010 is granted
    reset_pulse();
    req = 3'b010;
    wait_grant("async_first");
    chk("async_pre", 32'(grant), 32'(3'b010));
    #2 reset = 1'b1;
    #1;
    chk("async_grant", 32'(grant), 32'(0));
    chk("async_busy", 32'(busy), 32'(0));
    chk("async_id", 32'(grant_id), 32'(0));
    @(negedge clock);
    #2 reset = 1'b0; req = 3'b111;
    wait_grant("async_after");
    chk("async_regrant", 32'(grant), 32'(3'b001));
    req = '0;
    repeat (3) @(negedge clock);

    // Randomized traffic, requests mostly held steady so timeouts also occur
    repeat (600) begin
      @(negedge clock);
      if ($urandom_range(0, 3) == 0) req = N'($urandom_range(0, 7));
      done = ($urandom_range(0, 4) == 0);
    end
    req = '0; done = 1'b0;
    repeat (4) @(negedge clock);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/onehot_rr_arbiter.md
Name: onehot_rr_arbiter

Overview:
- Round-robin arbiter that shares one resource among N requesters.
- Priority pointer is a one-hot token ring that rotates one position on every release, the same ring structure as the team's one-hot counters.
- Outputs a one-hot grant vector plus a binary grant index, so it can drive ledbar displays and downstream muxes directly.
- Enforces a maximum hold time so that one requester cannot starve the others.

Parameters:
- N, 3, number of requesters (2..8).
- MAX_HOLD, 8, max cycles a grant may be held before forced release; 0 disables the timeout.
- IDW, clog2(N), width of grant_id.

Ports:
- clock  input  1  single system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  N  request lines; bit i is requester i; level-sensitive.
- done  input  1  current grant holder finishes this cycle.
- grant  output  N  one-hot grant; all-zero when no grant is active.
- grant_id  output  IDW  binary index of the granted requester; 0 when idle.
- busy  output  1  high while in GRANT.
- timeout  output  1  one-cycle pulse when a grant is forcibly released.

Behaviour:
- Reset (asynchronous, applies immediately mid-operation):
  - grant=0, grant_id=0, busy=0, timeout=0.
  - ptr=one-hot bit0, hold_cnt=0, state=IDLE.
- States: IDLE, GRANT, GAP. All outputs are registered.
- IDLE:
  - If req is nonzero at the edge, select the first set req bit searching upward from ptr with wrap (i = ptr, ptr+1, ..., N-1, 0, ...).
  - At that edge: grant=onehot(sel), grant_id=sel, busy=1, hold_cnt=1, go to GRANT.
  - Latency: req seen at edge k gives grant visible after edge k.
  - If req=0, stay in IDLE.
- GRANT, release conditions at an edge:
  - (a) done=1;
  - (b) req[grant_id]=0;
  - (c) MAX_HOLD!=0 and hold_cnt==MAX_HOLD.
  - On release: grant=0, busy=0, ptr=rotate_left(grant) (bit N-1 wraps to bit0), go to GAP.
  - timeout=1 for exactly that one cycle, only if (c) holds and neither (a) nor (b) holds.
  - Otherwise increment hold_cnt, saturating at MAX_HOLD.
- GAP:
  - Exactly one dead cycle with grant=0.
  - timeout returns to 0.
  - Go to IDLE.
  - Minimum spacing between consecutive grants is therefore 2 cycles after release.
- Request sampling:
  - req of non-holders is ignored during GRANT and GAP; only the value at the IDLE edge is used.
  - Newly raised requests wait for the next arbitration.
- done with no grant active (IDLE/GAP) is ignored.
- MAX_HOLD=1: every grant lasts exactly 1 cycle and pulses timeout unless done or req drop releases it.
- Invariants (bench asserts):
  - grant is zero or one-hot.
  - ptr is always one-hot.
  - busy == (grant != 0).
  - grant_id is consistent with grant.
- hold_cnt width is clog2(MAX_HOLD+1); hold_cnt never exceeds MAX_HOLD.

Decomposition:
- Package onehot_arb_pkg:
  - state enum {IDLE, GRANT, GAP};
  - default N and MAX_HOLD constants;
  - function onehot_to_index.
- Sub-module rr_pick (combinational):
  - inputs req[N] and ptr[N] (one-hot);
  - outputs pick[N] (one-hot, or zero when req=0) and any.
  - Implemented as a double-width priority search.
- Top holds the state register, ptr ring, hold counter and output registers.

Test Plan:
- Reset: reset=1 for 2 cycles, then 0 with req=000 -> grant=000, busy=0, grant_id=0, timeout=0 for 5 cycles.
- Rotation: req=111 held, done pulsed 1 cycle after each grant -> grant order 001,010,100,001, with one GAP cycle between each.
- Skip: ptr=bit1 (after granting req0), req=101 -> grant=100, grant_id=2; after release, req=101 -> grant=001 (wrap).
- Timeout: MAX_HOLD=4, req=001 steady, done=0 -> grant=001 for exactly 4 cycles, timeout=1 on the release cycle only, regrant 001 after GAP+IDLE.
- Simultaneous: done=1 on the same edge that hold_cnt reaches MAX_HOLD -> release with timeout=0.
- Async reset mid-grant: assert reset while grant=010, between clock edges -> grant=000 and busy=0 immediately; after deassert with req=111 -> first grant=001.
